// File: rtl/cmp_sched.sv
// Round-robin scheduler sharing one external comparison unit between the branch
// port (0) and the SLT/SLTU port (1), with one issue register and per-port response buffers.
module cmp_sched #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_funct3,
  input  logic [WIDTH-1:0] req0_ra,
  input  logic [WIDTH-1:0] req0_rb,
  input  logic [TAGW-1:0]  req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_unsigned,
  input  logic [WIDTH-1:0] req1_ra,
  input  logic [WIDTH-1:0] req1_rb,
  input  logic [TAGW-1:0]  req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp0_taken,
  output logic             rsp0_illegal,
  output logic [TAGW-1:0]  rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [TAGW-1:0]  rsp1_tag,
  output logic [WIDTH-1:0] cu_ra,
  output logic [WIDTH-1:0] cu_rb,
  output logic             cu_lt,
  output logic             cu_invert,
  output logic             cu_unsigned,
  input  logic             cu_out
);

  // Branch funct3 -> {illegal, lt, invert, unsigned}; lt=0 selects equality.
  function automatic logic [3:0] decode_br(input logic [2:0] f3);
    logic [3:0] d;
    d = 4'b0000;
    case (f3)
      3'b000:  d = 4'b0000;
      3'b001:  d = 4'b0010;
      3'b100:  d = 4'b0100;
      3'b101:  d = 4'b0110;
      3'b110:  d = 4'b0101;
      3'b111:  d = 4'b0111;
      default: d = 4'b1000;
    endcase
    return d;
  endfunction

  logic             rr_p0;

  logic             vld_p1;
  logic             s_port_p1;
  logic             s_lt_p1;
  logic             s_inv_p1;
  logic             s_uns_p1;
  logic             s_ill_p1;
  logic [WIDTH-1:0] s_ra_p1;
  logic [WIDTH-1:0] s_rb_p1;
  logic [TAGW-1:0]  s_tag_p1;

  logic             vld0_p2;
  logic             taken0_p2;
  logic             ill0_p2;
  logic [TAGW-1:0]  tag0_p2;
  logic             vld1_p2;
  logic             lt1_p2;
  logic [TAGW-1:0]  tag1_p2;

  logic             pop0;
  logic             pop1;
  logic             dest_free;
  logic             drain;
  logic             s_accept;
  logic             gnt0;
  logic             gnt1;
  logic             fire0;
  logic             fire1;
  logic             contest;
  logic             result;
  logic             load0;
  logic             load1;
  logic [3:0]       dec0;

  always_comb begin
    pop0      = vld0_p2 & rsp0_ready;
    pop1      = vld1_p2 & rsp1_ready;
    dest_free = s_port_p1 ? (!vld1_p2 | pop1) : (!vld0_p2 | pop0);
    drain     = vld_p1 & dest_free;
    s_accept  = !vld_p1 | drain;
    contest   = req0_valid & req1_valid;
    gnt0      = req0_valid & (!req1_valid | !rr_p0);
    gnt1      = req1_valid & (!req0_valid | rr_p0);
    fire0     = gnt0 & s_accept & !flush & !rst;
    fire1     = gnt1 & s_accept & !flush & !rst;
    result    = cu_out & !s_ill_p1;
    load0     = drain & !s_port_p1 & !flush;
    load1     = drain & s_port_p1 & !flush;
    dec0      = decode_br(req0_funct3);
  end

  assign req0_ready = fire0;
  assign req1_ready = fire1;

  // Stage 0 -> 1: arbitration and capture into the issue register
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_p0  <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else begin
      if (contest & (fire0 | fire1))
        rr_p0 <= fire0;
      if (fire0 | fire1)
        vld_p1 <= 1'b1;
      else if (drain)
        vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fire0) begin
      s_port_p1 <= 1'b0;
      s_ra_p1   <= req0_ra;
      s_rb_p1   <= req0_rb;
      s_tag_p1  <= req0_tag;
      s_ill_p1  <= dec0[3];
      s_lt_p1   <= dec0[2];
      s_inv_p1  <= dec0[1];
      s_uns_p1  <= dec0[0];
    end else if (fire1) begin
      s_port_p1 <= 1'b1;
      s_ra_p1   <= req1_ra;
      s_rb_p1   <= req1_rb;
      s_tag_p1  <= req1_tag;
      s_ill_p1  <= 1'b0;
      s_lt_p1   <= 1'b1;
      s_inv_p1  <= 1'b0;
      s_uns_p1  <= req1_unsigned;
    end
  end

  assign cu_ra       = vld_p1 ? s_ra_p1 : '0;
  assign cu_rb       = vld_p1 ? s_rb_p1 : '0;
  assign cu_lt       = vld_p1 & s_lt_p1;
  assign cu_invert   = vld_p1 & s_inv_p1;
  assign cu_unsigned = vld_p1 & s_uns_p1;

  // Stage 1 -> 2: comparator result captured into the per-port response buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      vld0_p2 <= 1'b0;
      vld1_p2 <= 1'b0;
    end else if (flush) begin
      vld0_p2 <= 1'b0;
      vld1_p2 <= 1'b0;
    end else begin
      if (load0)
        vld0_p2 <= 1'b1;
      else if (pop0)
        vld0_p2 <= 1'b0;
      if (load1)
        vld1_p2 <= 1'b1;
      else if (pop1)
        vld1_p2 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken0_p2 <= 1'b0;
      ill0_p2   <= 1'b0;
      tag0_p2   <= '0;
      lt1_p2    <= 1'b0;
      tag1_p2   <= '0;
    end else begin
      if (load0) begin
        taken0_p2 <= result;
        ill0_p2   <= s_ill_p1;
        tag0_p2   <= s_tag_p1;
      end
      if (load1) begin
        lt1_p2  <= result;
        tag1_p2 <= s_tag_p1;
      end
    end
  end

  assign rsp0_valid   = vld0_p2;
  assign rsp0_taken   = taken0_p2;
  assign rsp0_illegal = ill0_p2;
  assign rsp0_tag     = tag0_p2;
  assign rsp1_valid   = vld1_p2;
  assign rsp1_result  = {{(WIDTH-1){1'b0}}, lt1_p2};
  assign rsp1_tag     = tag1_p2;

endmodule

// File: tb/tb_cmp_sched.sv
// Self-checking bench for cmp_sched: models the external comparator, keeps a
// per-port scoreboard of expected responses and runs one task per scenario.
module tb_cmp_sched;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic        req0_valid, req0_ready, req1_valid, req1_ready, req1_unsigned;
  logic [2:0]  req0_funct3;
  logic [31:0] req0_ra, req0_rb, req1_ra, req1_rb;
  logic [4:0]  req0_tag, req1_tag, rsp0_tag, rsp1_tag;
  logic        rsp0_valid, rsp0_ready, rsp0_taken, rsp0_illegal;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp1_result, cu_ra, cu_rb;
  logic        cu_lt, cu_invert, cu_unsigned, cu_out;

  typedef struct packed { logic taken; logic ill; logic [4:0] tag; } e0_t;
  typedef struct packed { logic [31:0] res; logic [4:0] tag; } e1_t;
  e0_t q0[$];
  e1_t q1[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // External comparison unit: equality or less-than, optional inversion.
  always_comb begin
    cu_out = 1'b0;
    if (cu_lt) cu_out = cu_unsigned ? (cu_ra < cu_rb) : ($signed(cu_ra) < $signed(cu_rb));
    else       cu_out = (cu_ra == cu_rb);
    cu_out = cu_out ^ cu_invert;
  end

  cmp_sched dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct3(req0_funct3),
    .req0_ra(req0_ra), .req0_rb(req0_rb), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_unsigned(req1_unsigned),
    .req1_ra(req1_ra), .req1_rb(req1_rb), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_taken(rsp0_taken),
    .rsp0_illegal(rsp0_illegal), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_tag(rsp1_tag),
    .cu_ra(cu_ra), .cu_rb(cu_rb), .cu_lt(cu_lt), .cu_invert(cu_invert),
    .cu_unsigned(cu_unsigned), .cu_out(cu_out)
  );

  function automatic e0_t br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag);
    e0_t e;
    e.tag = tag; e.ill = 1'b0; e.taken = 1'b0;
    case (f3)
      3'b000: e.taken = (a == b);
      3'b001: e.taken = (a != b);
      3'b100: e.taken = ($signed(a) < $signed(b));
      3'b101: e.taken = ($signed(a) >= $signed(b));
      3'b110: e.taken = (a < b);
      3'b111: e.taken = (a >= b);
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic e1_t slt_ref(input logic uns, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] tag);
    e1_t e;
    e.tag = tag;
    e.res = 32'd0;
    e.res[0] = uns ? (a < b) : ($signed(a) < $signed(b));
    return e;
  endfunction

  task automatic monitor();
    e0_t g0;
    e1_t g1;
    forever begin
      @(negedge clk);
      if (rst || flush) begin
        q0.delete();
        q1.delete();
      end else begin
        if (rsp0_valid && rsp0_ready) begin
          checks++;
          if (q0.size() == 0) begin
            errors++;
            $display("FAIL rsp0_unexpected tag=%0d taken=%0b expected no response", rsp0_tag, rsp0_taken);
          end else begin
            g0 = q0.pop_front();
            if ({rsp0_taken, rsp0_illegal, rsp0_tag} !== g0) begin
              errors++;
              $display("FAIL rsp0_data got taken=%0b ill=%0b tag=%0d expected taken=%0b ill=%0b tag=%0d",
                       rsp0_taken, rsp0_illegal, rsp0_tag, g0.taken, g0.ill, g0.tag);
            end
          end
        end
        if (rsp1_valid && rsp1_ready) begin
          checks++;
          if (q1.size() == 0) begin
            errors++;
            $display("FAIL rsp1_unexpected tag=%0d result=%0h expected no response", rsp1_tag, rsp1_result);
          end else begin
            g1 = q1.pop_front();
            if ({rsp1_result, rsp1_tag} !== g1) begin
              errors++;
              $display("FAIL rsp1_data got result=%0h tag=%0d expected result=%0h tag=%0d",
                       rsp1_result, rsp1_tag, g1.res, g1.tag);
            end
          end
        end
        if (req0_valid && req0_ready) q0.push_back(br_ref(req0_funct3, req0_ra, req0_rb, req0_tag));
        if (req1_valid && req1_ready) q1.push_back(slt_ref(req1_unsigned, req1_ra, req1_rb, req1_tag));
      end
    end
  endtask

  task automatic drive0(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    req0_valid = 1'b1; req0_funct3 = f3; req0_ra = a; req0_rb = b; req0_tag = t;
  endtask

  task automatic drive1(input logic u, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    req1_valid = 1'b1; req1_unsigned = u; req1_ra = a; req1_rb = b; req1_tag = t;
  endtask

  // Returns at acceptance edge + 1.
  task automatic wait_acc(input int port);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout port=%0d ready=0 expected 1 within 100 cycles", port);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 50; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && !rsp0_valid && !rsp1_valid) break;
      @(posedge clk); #1;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain pending q0=%0d q1=%0d expected 0 0", q0.size(), q1.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b expected 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({rsp0_valid, rsp1_valid, cu_lt, cu_invert, cu_unsigned} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b expected 00000",
                         {rsp0_valid, rsp1_valid, cu_lt, cu_invert, cu_unsigned});
    end
    checks++;
    if ({cu_ra, cu_rb, rsp1_result, rsp0_tag, rsp1_tag, rsp0_taken, rsp0_illegal} !== '0) begin
      errors++; $display("FAIL reset_data got cu_ra=%0h rsp1_result=%0h rsp0_tag=%0d expected 0",
                         cu_ra, rsp1_result, rsp0_tag);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic test_branch();
    drive0(3'b100, 32'hFFFF_FFFF, 32'h1, 5'd1);
    wait_acc(0);
    req0_valid = 1'b0;
    checks++;
    if ({rsp0_valid, cu_lt} !== 2'b01) begin
      errors++; $display("FAIL blt_issue got rsp0_valid=%0b cu_lt=%0b expected 0 1", rsp0_valid, cu_lt);
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp0_taken, rsp0_tag} !== {1'b1, 1'b1, 5'd1}) begin
      errors++; $display("FAIL blt_rsp got valid=%0b taken=%0b tag=%0d expected 1 1 1",
                         rsp0_valid, rsp0_taken, rsp0_tag);
    end
    drive0(3'b110, 32'hFFFF_FFFF, 32'h1, 5'd2);
    wait_acc(0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp0_taken} !== 2'b10) begin
      errors++; $display("FAIL bltu_rsp got valid=%0b taken=%0b expected 1 0", rsp0_valid, rsp0_taken);
    end
    wait_empty();
  endtask

  task automatic test_slt();
    drive1(1'b1, 32'h1, 32'hFFFF_FFFF, 5'd7);
    wait_acc(1);
    req1_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rsp1_valid, rsp1_result, rsp1_tag} !== {1'b1, 32'd1, 5'd7}) begin
      errors++; $display("FAIL sltu_rsp got valid=%0b result=%0h tag=%0d expected 1 1 7",
                         rsp1_valid, rsp1_result, rsp1_tag);
    end
    drive1(1'b0, 32'h1, 32'hFFFF_FFFF, 5'd8);
    wait_acc(1);
    req1_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rsp1_valid, rsp1_result, rsp1_tag} !== {1'b1, 32'd0, 5'd8}) begin
      errors++; $display("FAIL slt_rsp got valid=%0b result=%0h tag=%0d expected 1 0 8",
                         rsp1_valid, rsp1_result, rsp1_tag);
    end
    wait_empty();
  endtask

  task automatic test_arbitration();
    logic e0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive0(3'b101, 32'(i), 32'd2, 5'(10 + i));
      drive1(1'b0, 32'(i), 32'd1, 5'(20 + i));
      @(negedge clk);
      e0 = (i % 2 == 0);
      checks++;
      if ({req0_ready, req1_ready} !== {e0, !e0}) begin
        errors++; $display("FAIL arb_grant cycle=%0d got %b expected %b", i,
                           {req0_ready, req1_ready}, {e0, !e0});
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_empty();
  endtask

  task automatic test_backpressure();
    rsp0_ready = 1'b0;
    drive0(3'b000, 32'd5, 32'd5, 5'd20);
    wait_acc(0);
    drive0(3'b001, 32'd5, 32'd6, 5'd21);
    wait_acc(0);
    drive0(3'b100, 32'd9, 32'd3, 5'd22);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({req0_ready, rsp0_valid, rsp0_tag, rsp0_taken} !== {1'b0, 1'b1, 5'd20, 1'b1}) begin
        errors++; $display("FAIL bp_stall got ready=%0b valid=%0b tag=%0d taken=%0b expected 0 1 20 1",
                           req0_ready, rsp0_valid, rsp0_tag, rsp0_taken);
      end
      @(posedge clk); #1;
    end
    rsp0_ready = 1'b1;
    wait_acc(0);
    req0_valid = 1'b0;
    wait_empty();
  endtask

  task automatic test_illegal();
    drive0(3'b011, 32'd5, 32'd5, 5'd30);
    wait_acc(0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp0_illegal, rsp0_taken} !== 3'b110) begin
      errors++; $display("FAIL illegal_rsp got valid=%0b ill=%0b taken=%0b expected 1 1 0",
                         rsp0_valid, rsp0_illegal, rsp0_taken);
    end
    drive0(3'b000, 32'd5, 32'd5, 5'd31);
    wait_acc(0);
    drive0(3'b001, 32'd5, 32'd5, 5'd32);
    wait_acc(0);
    req0_valid = 1'b0;
    wait_empty();
  endtask

  task automatic fill_all(input logic [4:0] base);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    drive0(3'b100, 32'd1, 32'd2, base);
    wait_acc(0);
    req0_valid = 1'b0;
    drive1(1'b0, 32'd3, 32'd4, base + 5'd1);
    wait_acc(1);
    req1_valid = 1'b0;
    drive0(3'b000, 32'd7, 32'd7, base + 5'd2);
    wait_acc(0);
    checks++;
    if ({rsp0_valid, rsp1_valid, cu_ra} !== {1'b1, 1'b1, 32'd7}) begin
      errors++; $display("FAIL fill_state got rsp0_valid=%0b rsp1_valid=%0b cu_ra=%0h expected 1 1 7",
                         rsp0_valid, rsp1_valid, cu_ra);
    end
    drive0(3'b000, 32'd8, 32'd8, base + 5'd3);
  endtask

  task automatic check_killed(input string what);
    checks++;
    if ({rsp0_valid, rsp1_valid, req0_ready, cu_ra} !== {3'b000, 32'd0}) begin
      errors++; $display("FAIL %s_kill got rsp0_valid=%0b rsp1_valid=%0b ready=%0b cu_ra=%0h expected all 0",
                         what, rsp0_valid, rsp1_valid, req0_ready, cu_ra);
    end
  endtask

  task automatic test_flush();
    fill_all(5'd16);
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready got %0b expected 0", req0_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; req0_valid = 1'b0;
    check_killed("flush");
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    drive0(3'b101, 32'd4, 32'd4, 5'd25);
    wait_acc(0);
    req0_valid = 1'b0;
    wait_empty();
  endtask

  task automatic test_reset_mid();
    fill_all(5'd8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0;
    check_killed("rst");
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    drive0(3'b111, 32'd1, 32'd9, 5'd3);
    drive1(1'b1, 32'd2, 32'd9, 5'd4);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rst_rr got %b expected 10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_acc(1);
    req1_valid = 1'b0;
    wait_empty();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_funct3 = 3'b000; req0_ra = '0; req0_rb = '0; req0_tag = '0;
    req1_unsigned = 1'b0; req1_ra = '0; req1_rb = '0; req1_tag = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    fork
      monitor();
    join_none
    @(posedge clk); #1;
    test_reset();
    test_branch();
    test_slt();
    test_arbitration();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
